// File: rtl/cve2_pkg.sv
// Shared types for the cve2 sleep/clock-enable controller.
package cve2_pkg;

    typedef enum logic [1:0] {
        SLP_RUN,
        SLP_IDLE,
        SLP_SLEEP,
        SLP_WAKE
    } sleep_state_e;

    // Counter width large enough for the longer of the idle and wake countdowns.
    function automatic int unsigned sleep_cnt_w(input int unsigned idle_cycles,
                                                input int unsigned wake_latency);
        int unsigned m;
        m = 1;
        if (idle_cycles > m) m = idle_cycles;
        if (wake_latency > m) m = wake_latency;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cve2_sleep_ctrl_if.sv
// Per-hart core-side signals of the sleep controller, grouped as one bundle.
interface cve2_sleep_ctrl_if #(
    parameter int unsigned NumHarts = 1
);
    logic [NumHarts-1:0] fetch_enable_i;
    logic [NumHarts-1:0] core_busy_i;
    logic [NumHarts-1:0] irq_pending_i;
    logic [NumHarts-1:0] irq_nm_i;
    logic [NumHarts-1:0] debug_req_i;
    logic [NumHarts-1:0] fetch_enable_o;
    logic [NumHarts-1:0] clk_en_o;
    logic [NumHarts-1:0] core_sleep_o;

    modport slave (
        input  fetch_enable_i, core_busy_i, irq_pending_i, irq_nm_i, debug_req_i,
        output fetch_enable_o, clk_en_o, core_sleep_o
    );

    modport master (
        output fetch_enable_i, core_busy_i, irq_pending_i, irq_nm_i, debug_req_i,
        input  fetch_enable_o, clk_en_o, core_sleep_o
    );
endinterface

// File: rtl/cve2_sleep_fsm.sv
// One hart's run/idle/sleep/wake FSM with its countdown and sticky fetch enable.
module cve2_sleep_fsm
    import cve2_pkg::*;
#(
    parameter int unsigned IdleCycles  = 0,
    parameter int unsigned WakeLatency = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic test_en_i,
    input  logic fetch_enable_i,
    input  logic core_busy_i,
    input  logic irq_pending_i,
    input  logic irq_nm_i,
    input  logic debug_req_i,
    output logic fetch_enable_o,
    output logic clk_en_o
);

    localparam int unsigned CntW        = sleep_cnt_w(IdleCycles, WakeLatency);
    localparam int unsigned IdleLoadInt = (IdleCycles > 0) ? IdleCycles - 1 : 0;
    localparam int unsigned WakeLoadInt = (WakeLatency > 0) ? WakeLatency - 1 : 0;
    localparam logic [CntW-1:0] IdleLoad = IdleLoadInt[CntW-1:0];
    localparam logic [CntW-1:0] WakeLoad = WakeLoadInt[CntW-1:0];
    localparam logic [CntW-1:0] CntOne   = {{(CntW-1){1'b0}}, 1'b1};

    sleep_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fetch_en_q;
    logic            wake;
    logic            active;
    logic            clk_en;

    assign wake   = debug_req_i | irq_pending_i | irq_nm_i;
    assign active = core_busy_i | wake;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_en  = 1'b0;
        case (state_q)
            SLP_RUN: begin
                clk_en = 1'b1;
                if (!active) begin
                    if (IdleCycles == 0) begin
                        state_d = SLP_SLEEP;
                    end else begin
                        state_d = SLP_IDLE;
                        cnt_d   = IdleLoad;
                    end
                end
            end
            SLP_IDLE: begin
                clk_en = 1'b1;
                if (active) begin
                    state_d = SLP_RUN;
                end else if (cnt_q == '0) begin
                    state_d = SLP_SLEEP;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            SLP_SLEEP: begin
                // Combinational wake bypass only when there is no wake latency.
                clk_en = wake & (WakeLatency == 0);
                if (active) begin
                    if (WakeLatency == 0) begin
                        state_d = SLP_RUN;
                    end else begin
                        state_d = SLP_WAKE;
                        cnt_d   = WakeLoad;
                    end
                end
            end
            SLP_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = SLP_RUN;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = SLP_SLEEP;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SLP_SLEEP;
            cnt_q      <= '0;
            fetch_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fetch_enable_i) begin
                fetch_en_q <= 1'b1;
            end
        end
    end

    assign fetch_enable_o = fetch_en_q;
    assign clk_en_o       = clk_en | test_en_i;

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// Multi-hart clock-enable and wake controller: one independent sleep FSM per hart.
module cve2_sleep_ctrl
    import cve2_pkg::*;
#(
    parameter int unsigned NumHarts    = 1,
    parameter int unsigned IdleCycles  = 0,
    parameter int unsigned WakeLatency = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    test_en_i,
    cve2_sleep_ctrl_if.slave        bus_if,
    output logic                    all_sleep_o
);

    logic [NumHarts-1:0] clk_en;
    logic [NumHarts-1:0] fetch_en;

    for (genvar h = 0; h < int'(NumHarts); h++) begin : g_hart
        cve2_sleep_fsm #(
            .IdleCycles  (IdleCycles),
            .WakeLatency (WakeLatency)
        ) u_fsm (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .test_en_i      (test_en_i),
            .fetch_enable_i (bus_if.fetch_enable_i[h]),
            .core_busy_i    (bus_if.core_busy_i[h]),
            .irq_pending_i  (bus_if.irq_pending_i[h]),
            .irq_nm_i       (bus_if.irq_nm_i[h]),
            .debug_req_i    (bus_if.debug_req_i[h]),
            .fetch_enable_o (fetch_en[h]),
            .clk_en_o       (clk_en[h])
        );
    end

    assign bus_if.fetch_enable_o = fetch_en;
    assign bus_if.clk_en_o       = clk_en;
    assign bus_if.core_sleep_o   = ~clk_en;
    assign all_sleep_o           = &(~clk_en);

endmodule
